// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the core memory stage and a word-wide data-memory port.
// Build option LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of clearing the offending address bits.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  // state | meaning
  // IDLE  | ready to accept a request
  // REQ   | mem_req asserted, waiting for mem_gnt
  // WAIT  | request granted, waiting for mem_rvalid
  // RESP  | one-cycle response strobe, then back to IDLE
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [1:0]  cap_lo;

  logic [1:0]  size;
  logic        illegal;
  logic        fault;
  logic [1:0]  lo_eff;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] lane;
  logic [31:0] ext_rdata;

  always_comb begin
    size = req_funct3[1:0];
    if (req_we)
      illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size == 2'b01) && req_addr[0]) ||
                      ((size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign fault  = illegal || misaligned;
  assign lo_eff = req_addr[1:0];
`else
  // Without trapping, the offset is truncated to the natural alignment of the access.
  assign fault = illegal;
  always_comb begin
    case (size)
      2'b01:   lo_eff = {req_addr[1], 1'b0};
      2'b10:   lo_eff = 2'b00;
      default: lo_eff = req_addr[1:0];
    endcase
  end
`endif

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = '0;
    if (req_we) begin
      case (size)
        2'b00: begin
          be_n    = 4'b0001 << lo_eff;
          wdata_n = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << lo_eff;
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    lane = mem_rdata >> {cap_lo, 3'b000};
    case (cap_f3)
      3'b000:  ext_rdata = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ext_rdata = {24'd0, lane[7:0]};
      3'b001:  ext_rdata = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ext_rdata = {16'd0, lane[15:0]};
      default: ext_rdata = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_f3     <= '0;
      cap_lo     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_lo    <= lo_eff;
            if (fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
            end
          end
        end

        REQ: begin
          // Timeout wins over a grant arriving in the same cycle: the access is abandoned.
          if (cnt == TC_LAST) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
            if (mem_gnt) begin
              state     <= WAIT;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_be    <= '0;
              mem_wdata <= '0;
            end
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= cap_we ? 32'd0 : ext_rdata;
          end else if (cnt == TC_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl built with TIMEOUT_CYCLES=8.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request at a negedge and plays the memory side. gnt_dly/rv_dly count REQ/WAIT
  // cycles before the strobe (-1 = never). lat = negedges from accept until resp_valid (0 = no response).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, output int lat, output logic [31:0] r_rdata,
                        output logic r_err, output int req_cyc, output logic stable,
                        output logic [31:0] a_addr, output logic [3:0] a_be,
                        output logic [31:0] a_wdata, output logic a_we);
    int wait_cyc;
    logic saw_req;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    lat = 0; r_rdata = 32'h0; r_err = 1'b0; req_cyc = 0; wait_cyc = 0;
    stable = 1'b1; saw_req = 1'b0;
    a_addr = 32'h0; a_be = 4'h0; a_wdata = 32'h0; a_we = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (resp_valid) begin
        lat = i; r_rdata = resp_rdata; r_err = resp_err;
        break;
      end
      if (mem_req) begin
        if (!saw_req) begin
          a_addr = mem_addr; a_be = mem_be; a_wdata = mem_wdata; a_we = mem_we;
        end else if (mem_addr !== a_addr || mem_be !== a_be || mem_wdata !== a_wdata || mem_we !== a_we) begin
          stable = 1'b0;
        end
        saw_req = 1'b1;
        if (req_cyc == gnt_dly) mem_gnt = 1'b1;
        req_cyc++;
      end else if (saw_req) begin
        if (wait_cyc == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        wait_cyc++;
      end
    end
  endtask

  int          lat, rc;
  logic [31:0] rd, aa, aw;
  logic        re, st, awe;
  logic [3:0]  ab;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0;
    req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_be", mem_be, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LB at byte 3, minimum latency
    access(0, 3'b000, 32'h1003, 0, 0, 0, 32'h80FF_1234, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("lb_lat", lat, 3);
    chk("lb_addr", aa, 32'h1000);
    chk("lb_be", ab, 4'b1111);
    chk("lb_we", awe, 0);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    chk("lb_err", re, 0);
    @(negedge clk);
    chk("lb_resp_one_cycle", resp_valid, 0);
    chk("lb_ready_back", req_ready, 1);

    access(0, 3'b101, 32'h2002, 0, 0, 0, 32'hBEEF_0000, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("lhu_rdata", rd, 32'h0000_BEEF);
    @(negedge clk);
    access(0, 3'b001, 32'h2002, 0, 0, 0, 32'hBEEF_0000, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("lh_rdata", rd, 32'hFFFF_BEEF);
    @(negedge clk);
    access(0, 3'b100, 32'h1002, 0, 0, 0, 32'h11C3_2233, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("lbu_rdata", rd, 32'h0000_00C3);
    @(negedge clk);

    access(1, 3'b001, 32'h3002, 32'h0000_A5C3, 0, 0, 32'hDEAD_BEEF, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("sh_be", ab, 4'b1100);
    chk("sh_wdata", aw, 32'hA5C3_A5C3);
    chk("sh_we", awe, 1);
    chk("sh_addr", aa, 32'h3000);
    chk("sh_rdata", rd, 0);
    chk("sh_err", re, 0);
    @(negedge clk);
    access(1, 3'b000, 32'h1001, 32'h0000_00AB, 0, 0, 32'h0, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("sb_be", ab, 4'b0010);
    chk("sb_wdata", aw, 32'hABAB_ABAB);
    @(negedge clk);
    access(1, 3'b010, 32'h1000, 32'h1234_5678, 1, 2, 32'h0, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("sw_be", ab, 4'b1111);
    chk("sw_wdata", aw, 32'h1234_5678);
    chk("sw_slow_lat", lat, 6);
    chk("sw_slow_err", re, 0);
    @(negedge clk);

    // Grant after 3 stalled cycles, no response: timeout 8 cycles after entering REQ
    access(0, 3'b010, 32'h5000, 0, 3, -1, 32'h0, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("to_req_cycles", rc, 4);
    chk("to_stable", st, 1);
    chk("to_lat", lat, 9);
    chk("to_err", re, 1);
    chk("to_rdata", rd, 0);
    chk("to_mem_req_low", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid_ignored", resp_valid, 0);
    chk("late_rvalid_ready", req_ready, 1);

    // Grant never arrives: timeout out of REQ
    access(0, 3'b010, 32'h5004, 0, -1, -1, 32'h0, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("to_nognt_req_cycles", rc, 8);
    chk("to_nognt_lat", lat, 9);
    chk("to_nognt_err", re, 1);
    @(negedge clk);

    access(0, 3'b010, 32'h4001, 0, 0, 0, 32'h1234_5678, lat, rd, re, rc, st, aa, ab, aw, awe);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", re, 1);
    chk("lw_mis_no_bus", rc, 0);
    chk("lw_mis_lat", lat, 1);
`else
    chk("lw_mis_addr", aa, 32'h4000);
    chk("lw_mis_rdata", rd, 32'h1234_5678);
    chk("lw_mis_err", re, 0);
`endif
    @(negedge clk);
    access(0, 3'b001, 32'h2001, 0, 0, 0, 32'h0000_8001, lat, rd, re, rc, st, aa, ab, aw, awe);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lh_mis_err", re, 1);
    chk("lh_mis_no_bus", rc, 0);
`else
    chk("lh_mis_rdata", rd, 32'hFFFF_8001);
    chk("lh_mis_err", re, 0);
`endif
    @(negedge clk);

    access(0, 3'b011, 32'h1000, 0, 0, 0, 32'h0, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("ill_ld_err", re, 1);
    chk("ill_ld_no_bus", rc, 0);
    chk("ill_ld_lat", lat, 1);
    chk("ill_ld_rdata", rd, 0);
    @(negedge clk);
    access(1, 3'b100, 32'h1000, 0, 0, 0, 32'h0, lat, rd, re, rc, st, aa, ab, aw, awe);
    chk("ill_st_err", re, 1);
    chk("ill_st_no_bus", rc, 0);
    @(negedge clk);

    // Reset asserted while in WAIT
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_in_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw_ready_low", req_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ready", req_ready, 1);
    chk("rstw_mem_req", mem_req, 0);
    chk("rstw_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rstw_no_resp_1", resp_valid, 0);
    @(negedge clk);
    chk("rstw_no_resp_2", resp_valid, 0);
    chk("rstw_idle_ready", req_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
